// File: rtl/mc_control_if.sv
// Handshake and strobe bundle between the multi-cycle sequencer and the
// datapath it controls. The master side is the sequencer itself; the slave
// side is the datapath / memories / MULT-DIV unit that answers it.
interface mc_control_if;
    logic [5:0] opcode;
    logic       imem_ack;
    logic       dmem_ack;
    logic       alu_done;
    logic       imem_req;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       alu_start;
    logic [2:0] alu_op;
    logic       dmem_req;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       illegal;
    logic       err;
    logic [2:0] state;

    modport master (
        input  opcode, imem_ack, dmem_ack, alu_done,
        output imem_req, ir_load, pc_inc, pc_load, alu_start, alu_op,
        output dmem_req, mem_read, mem_write, reg_write, illegal, err, state
    );

    modport slave (
        output opcode, imem_ack, dmem_ack, alu_done,
        input  imem_req, ir_load, pc_inc, pc_load, alu_start, alu_op,
        input  dmem_req, mem_read, mem_write, reg_write, illegal, err, state
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC/MEM -> WB.
// Strobes are decoded from the registered state, the latched opcode and the
// incoming acks, so a same-cycle ack advances the datapath without a bubble.
// A wait-cycle watchdog sends the core to HALT (sticky err) when a
// handshake never completes.
module mc_control #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mc_control_if.master    bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IDLE   = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_MULT  = 6'd2;
    localparam logic [5:0] OP_DIV   = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_STORE = 6'd5;
    localparam logic [5:0] OP_JUMP  = 6'd6;

    localparam logic [2:0] ALU_NONE = 3'b111;

    // Last wait cycle index still allowed before the watchdog fires.
    localparam logic [CNT_W-1:0] WD_LIMIT =
        (TIMEOUT == 32'd0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 32'd1);

    state_t           state_r;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_r;
    logic             err_r;
    logic             started_r;

    logic             wd_hit_s;
    logic [CNT_W-1:0] cnt_inc_s;

    logic             imem_req_s;
    logic             ir_load_s;
    logic             pc_inc_s;
    logic             pc_load_s;
    logic             alu_start_s;
    logic [2:0]       alu_op_s;
    logic             dmem_req_s;
    logic             mem_read_s;
    logic             mem_write_s;
    logic             reg_write_s;
    logic             illegal_s;

    function automatic logic is_muldiv(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_arith(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || is_muldiv(op);
    endfunction

    // The watchdog fires on the last permitted wait cycle; counter saturates
    // so a disabled watchdog never wraps.
    assign wd_hit_s  = (TIMEOUT != 32'd0) && (cnt_r >= WD_LIMIT);
    assign cnt_inc_s = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : (cnt_r + CNT_W'(1));

    // Sequencer state, latched opcode, wait counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_q      <= 6'd0;
            cnt_r     <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
            started_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_FETCH;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        state_r <= S_DECODE;
                    end else if (wd_hit_s) begin
                        state_r <= S_HALT;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                S_DECODE: begin
                    op_q  <= bus.opcode;
                    cnt_r <= {CNT_W{1'b0}};
                    if (is_arith(bus.opcode)) begin
                        state_r   <= S_EXEC;
                        started_r <= 1'b0;
                    end else if ((bus.opcode == OP_LOAD) || (bus.opcode == OP_STORE)) begin
                        state_r <= S_MEM;
                    end else begin
                        // JUMP, NOP and illegal opcodes all return to FETCH.
                        state_r <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    started_r <= 1'b1;
                    if (!is_muldiv(op_q)) begin
                        state_r <= S_WB;
                    end else if (bus.alu_done) begin
                        state_r <= S_WB;
                    end else if (wd_hit_s) begin
                        state_r <= S_HALT;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        if (op_q == OP_LOAD) begin
                            state_r <= S_WB;
                        end else begin
                            state_r <= S_FETCH;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end else if (wd_hit_s) begin
                        state_r <= S_HALT;
                        err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                S_WB: begin
                    state_r <= S_FETCH;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                S_HALT: begin
                    state_r <= S_HALT;
                    err_r   <= 1'b1;
                end
                default: begin
                    // Unused encoding: fail safe into HALT.
                    state_r <= S_HALT;
                    err_r   <= 1'b1;
                end
            endcase
        end
    end

    // Strobe decode from current state, latched opcode and same-cycle acks.
    always_comb begin
        imem_req_s  = 1'b0;
        ir_load_s   = 1'b0;
        pc_inc_s    = 1'b0;
        pc_load_s   = 1'b0;
        alu_start_s = 1'b0;
        alu_op_s    = ALU_NONE;
        dmem_req_s  = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                ir_load_s  = bus.imem_ack;
                pc_inc_s   = bus.imem_ack;
            end
            S_DECODE: begin
                pc_load_s = (bus.opcode == OP_JUMP);
                illegal_s = (bus.opcode[5:3] != 3'd0);
            end
            S_EXEC: begin
                alu_op_s    = op_q[2:0];
                alu_start_s = is_muldiv(op_q) && !started_r;
            end
            S_MEM: begin
                dmem_req_s  = 1'b1;
                mem_read_s  = (op_q == OP_LOAD);
                mem_write_s = (op_q == OP_STORE);
            end
            S_WB: begin
                reg_write_s = 1'b1;
                alu_op_s    = (op_q == OP_LOAD) ? ALU_NONE : op_q[2:0];
            end
            default: begin
                alu_op_s = ALU_NONE;
            end
        endcase
    end

    assign bus.imem_req  = imem_req_s;
    assign bus.ir_load   = ir_load_s;
    assign bus.pc_inc    = pc_inc_s;
    assign bus.pc_load   = pc_load_s;
    assign bus.alu_start = alu_start_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.dmem_req  = dmem_req_s;
    assign bus.mem_read  = mem_read_s;
    assign bus.mem_write = mem_write_s;
    assign bus.reg_write = reg_write_s;
    assign bus.illegal   = illegal_s;
    assign bus.err       = err_r;
    assign bus.state     = state_r;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each driven cycle pushes the expected
// state and strobe vector; a negedge monitor pops and compares. Two
// instances share stimulus: dut0 with the default watchdog, dut1 with
// TIMEOUT=4 for the boundary cases.
module tb_mc_control;

    logic clk;
    logic rst_n;

    mc_control_if bus0 ();
    mc_control_if bus1 ();

    mc_control dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    mc_control #(.TIMEOUT(4), .CNT_W(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_IDLE   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd7;

    // Vector order: imem_req ir_load pc_inc pc_load alu_start alu_op[2:0]
    //               dmem_req mem_read mem_write reg_write illegal err
    localparam logic [13:0] E_IDLE = {5'b00000, 3'b111, 6'b000000};
    localparam logic [13:0] E_HALT = {5'b00000, 3'b111, 5'b00000, 1'b1};

    typedef struct packed {
        logic        sel;
        logic [2:0]  st;
        logic [13:0] out;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_chk;
    int n_err;

    logic [13:0] out0;
    logic [13:0] out1;

    assign out0 = {bus0.imem_req, bus0.ir_load, bus0.pc_inc, bus0.pc_load, bus0.alu_start,
                   bus0.alu_op, bus0.dmem_req, bus0.mem_read, bus0.mem_write,
                   bus0.reg_write, bus0.illegal, bus0.err};
    assign out1 = {bus1.imem_req, bus1.ir_load, bus1.pc_inc, bus1.pc_load, bus1.alu_start,
                   bus1.alu_op, bus1.dmem_req, bus1.mem_read, bus1.mem_write,
                   bus1.reg_write, bus1.illegal, bus1.err};

    function automatic logic [13:0] e_fetch(input logic a);
        return {1'b1, a, a, 1'b0, 1'b0, 3'b111, 6'b000000};
    endfunction

    function automatic logic [13:0] e_dec(input logic pcl, input logic ill);
        return {3'b000, pcl, 1'b0, 3'b111, 4'b0000, ill, 1'b0};
    endfunction

    function automatic logic [13:0] e_exec(input logic [2:0] op, input logic st);
        return {4'b0000, st, op, 6'b000000};
    endfunction

    function automatic logic [13:0] e_mem(input logic rd, input logic wr);
        return {5'b00000, 3'b111, 1'b1, rd, wr, 3'b000};
    endfunction

    function automatic logic [13:0] e_wb(input logic [2:0] op);
        return {5'b00000, op, 3'b000, 1'b1, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic ia, input logic da, input logic ad);
        bus0.opcode = op;  bus1.opcode = op;
        bus0.imem_ack = ia; bus1.imem_ack = ia;
        bus0.dmem_ack = da; bus1.dmem_ack = da;
        bus0.alu_done = ad; bus1.alu_done = ad;
    endtask

    // One clock cycle of stimulus plus the expectation for that cycle.
    task automatic cyc(input logic sel, input string tag, input logic [5:0] op,
                       input logic ia, input logic da, input logic ad,
                       input logic [2:0] est, input logic [13:0] eout);
        exp_t e;
        @(posedge clk);
        #1;
        drive(op, ia, da, ad);
        e.sel = sel;
        e.st  = est;
        e.out = eout;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(6'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_state0", 32'(bus0.state), 32'(S_IDLE));
        check("rst_out0", 32'(out0), 32'(E_IDLE));
        check("rst_out1", 32'(out1), 32'(E_IDLE));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: compare the oldest expectation away from the edge.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.sel) begin
                check({t, "/state"}, 32'(bus1.state), 32'(e.st));
                check({t, "/out"}, 32'(out1), 32'(e.out));
            end else begin
                check({t, "/state"}, 32'(bus0.state), 32'(e.st));
                check({t, "/out"}, 32'(out0), 32'(e.out));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(6'd0, 1'b0, 1'b0, 1'b0);

        // ADD with every ack tied high: 0,1,2,4 then FETCH at cycle 5.
        do_reset();
        cyc(1'b0, "add_f",  6'd0, 1'b1, 1'b1, 1'b1, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "add_d",  6'd0, 1'b1, 1'b1, 1'b1, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "add_e",  6'd0, 1'b1, 1'b1, 1'b1, S_EXEC,   e_exec(3'b000, 1'b0));
        cyc(1'b0, "add_w",  6'd0, 1'b1, 1'b1, 1'b1, S_WB,     e_wb(3'b000));
        cyc(1'b0, "add_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b0));

        // SUB, then STORE (3 cycles), then NOP (2 cycles), back to back.
        do_reset();
        cyc(1'b0, "sub_f",  6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "sub_d",  6'd1, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "sub_e",  6'd0, 1'b0, 1'b0, 1'b0, S_EXEC,   e_exec(3'b001, 1'b0));
        cyc(1'b0, "sub_w",  6'd0, 1'b0, 1'b1, 1'b0, S_WB,     e_wb(3'b001));
        cyc(1'b0, "st_f",   6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "st_d",   6'd5, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "st_m",   6'd0, 1'b0, 1'b1, 1'b0, S_MEM,    e_mem(1'b0, 1'b1));
        cyc(1'b0, "nop_f",  6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "nop_d",  6'd7, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "nop_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b0));

        // LOAD with dmem_ack on the 4th MEM cycle; the TIMEOUT=4 instance must
        // survive the same wait.
        for (int s = 0; s < 2; s++) begin
            do_reset();
            cyc(s[0], "ld_f", 6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
            cyc(s[0], "ld_d", 6'd4, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
            for (int i = 0; i < 3; i++) begin
                cyc(s[0], "ld_mw", 6'd0, 1'b0, 1'b0, 1'b0, S_MEM, e_mem(1'b1, 1'b0));
            end
            cyc(s[0], "ld_ma", 6'd0, 1'b0, 1'b1, 1'b0, S_MEM,   e_mem(1'b1, 1'b0));
            cyc(s[0], "ld_w",  6'd0, 1'b0, 1'b1, 1'b0, S_WB,    e_wb(3'b111));
            cyc(s[0], "ld_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH, e_fetch(1'b0));
        end

        // DIV with alu_done 6 cycles after the single alu_start pulse.
        do_reset();
        cyc(1'b0, "div_f",  6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "div_d",  6'd3, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "div_e0", 6'd0, 1'b0, 1'b0, 1'b0, S_EXEC,   e_exec(3'b011, 1'b1));
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, "div_ew", 6'd0, 1'b0, 1'b0, 1'b0, S_EXEC, e_exec(3'b011, 1'b0));
        end
        cyc(1'b0, "div_ed", 6'd0, 1'b0, 1'b0, 1'b1, S_EXEC,   e_exec(3'b011, 1'b0));
        cyc(1'b0, "div_w",  6'd0, 1'b0, 1'b0, 1'b0, S_WB,     e_wb(3'b011));
        cyc(1'b0, "div_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b0));

        // MULT with alu_done in the start cycle itself.
        do_reset();
        cyc(1'b0, "mul_f",  6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "mul_d",  6'd2, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "mul_e",  6'd0, 1'b0, 1'b0, 1'b1, S_EXEC,   e_exec(3'b010, 1'b1));
        cyc(1'b0, "mul_w",  6'd0, 1'b0, 1'b0, 1'b1, S_WB,     e_wb(3'b010));
        cyc(1'b0, "mul_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b0));

        // JUMP then illegal 0x3F.
        do_reset();
        cyc(1'b0, "jmp_f",  6'd0,  1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "jmp_d",  6'd6,  1'b0, 1'b1, 1'b1, S_DECODE, e_dec(1'b1, 1'b0));
        cyc(1'b0, "ill_f",  6'd0,  1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "ill_d",  6'h3F, 1'b0, 1'b1, 1'b1, S_DECODE, e_dec(1'b0, 1'b1));
        cyc(1'b0, "ill_f2", 6'h3F, 1'b0, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b0));

        // Watchdog: four FETCH cycles without ack, then sticky HALT.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, "wd_f", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH, e_fetch(1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, "wd_halt", 6'd0, 1'b1, 1'b1, 1'b1, S_HALT, E_HALT);
        end

        // Watchdog: ack on the 4th FETCH cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, "wd4_f", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH, e_fetch(1'b0));
        end
        cyc(1'b1, "wd4_fa", 6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b1, "wd4_d",  6'd7, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b1, "wd4_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b0));

        // Reset during MEM of a STORE: mem_write drops at once.
        do_reset();
        cyc(1'b0, "rs_f", 6'd0, 1'b1, 1'b0, 1'b0, S_FETCH,  e_fetch(1'b1));
        cyc(1'b0, "rs_d", 6'd5, 1'b0, 1'b0, 1'b0, S_DECODE, e_dec(1'b0, 1'b0));
        cyc(1'b0, "rs_m", 6'd0, 1'b0, 1'b0, 1'b0, S_MEM,    e_mem(1'b0, 1'b1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_mid_state", 32'(bus0.state), 32'(S_IDLE));
        check("rs_mid_out", 32'(out0), 32'(E_IDLE));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, "rs_f2", 6'd0, 1'b0, 1'b0, 1'b0, S_FETCH, e_fetch(1'b0));

        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            check("sb_drain", 32'(exp_q.size()), 32'd0);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
